// File: rtl/usr_shift_sequencer.sv
// usr_shift_sequencer: command-driven rotate/load register with an IDLE/RUN/DONE FSM.
// Commands: HOLD, ROTR, ROTL (1..15 single-bit steps, one per clock) and LOAD.
// Optional macro USR_SEQ_QUEUE_EN adds a one-entry command slot so that a command
// can be accepted while busy and started directly when leaving DONE.
`timescale 1ns/1ps
module usr_shift_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [3:0]       cmd_count,
    input  logic             flush,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_ROTR = 2'b01;
    localparam logic [1:0] OP_ROTL = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [3:0]       cnt_q,   cnt_d;
    logic             dir_left_q, dir_left_d;

    logic [WIDTH-1:0] rot_right;
    logic [WIDTH-1:0] rot_left;
    logic             accept;

    // Single-bit rotations of the current register, built bit by bit.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
        assign rot_right[gi] = data_q[(gi + 1) % WIDTH];
        assign rot_left[gi]  = data_q[(gi + WIDTH - 1) % WIDTH];
    end

`ifdef USR_SEQ_QUEUE_EN
    logic             slot_valid_q, slot_valid_d;
    logic [1:0]       slot_op_q,    slot_op_d;
    logic [WIDTH-1:0] slot_data_q,  slot_data_d;
    logic [3:0]       slot_count_q, slot_count_d;

    // Ready while idle or while the slot can still take one command.
    assign cmd_ready = !reset && !flush && ((state_q == ST_IDLE) || !slot_valid_q);
`else
    // Ready only when idle; reset and flush both block acceptance.
    assign cmd_ready = !reset && !flush && (state_q == ST_IDLE);
`endif

    assign accept   = cmd_valid && cmd_ready;
    assign data_out = data_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

    // Next-state logic: run the FSM, pick the command to start, apply it.
    always_comb begin
        logic       exe_en;
        logic [1:0] exe_op;
        logic [WIDTH-1:0] exe_data;
        logic [3:0] exe_count;

        state_d    = state_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        dir_left_d = dir_left_q;
        exe_en     = 1'b0;
        exe_op     = cmd_op;
        exe_data   = cmd_data;
        exe_count  = cmd_count;
`ifdef USR_SEQ_QUEUE_EN
        slot_valid_d = slot_valid_q;
        slot_op_d    = slot_op_q;
        slot_data_d  = slot_data_q;
        slot_count_d = slot_count_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    exe_en = 1'b1;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
`ifdef USR_SEQ_QUEUE_EN
                    slot_valid_d = 1'b0;
`endif
                end else begin
                    data_d = dir_left_q ? rot_left : rot_right;
                    cnt_d  = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_DONE;
                    end
`ifdef USR_SEQ_QUEUE_EN
                    if (accept) begin
                        slot_valid_d = 1'b1;
                        slot_op_d    = cmd_op;
                        slot_data_d  = cmd_data;
                        slot_count_d = cmd_count;
                    end
`endif
                end
            end
            ST_DONE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
`ifdef USR_SEQ_QUEUE_EN
                    slot_valid_d = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
`ifdef USR_SEQ_QUEUE_EN
                    // A stored command takes priority; with an empty slot a
                    // command accepted now starts immediately.
                    if (slot_valid_q) begin
                        exe_en       = 1'b1;
                        exe_op       = slot_op_q;
                        exe_data     = slot_data_q;
                        exe_count    = slot_count_q;
                        slot_valid_d = 1'b0;
                    end else if (accept) begin
                        exe_en = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (exe_en) begin
            case (exe_op)
                OP_LOAD: begin
                    data_d  = exe_data;
                    cnt_d   = 4'd0;
                    state_d = ST_DONE;
                end
                OP_ROTR, OP_ROTL: begin
                    dir_left_d = (exe_op == OP_ROTL);
                    cnt_d      = exe_count;
                    state_d    = (exe_count == 4'd0) ? ST_DONE : ST_RUN;
                end
                default: begin
                    cnt_d   = 4'd0;
                    state_d = ST_DONE;
                end
            endcase
        end
    end

    // State, data and step counter registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            cnt_q      <= 4'd0;
            dir_left_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            dir_left_q <= dir_left_d;
        end
    end

`ifdef USR_SEQ_QUEUE_EN
    // One-entry command slot registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_valid_q <= 1'b0;
            slot_op_q    <= OP_HOLD;
            slot_data_q  <= '0;
            slot_count_q <= 4'd0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_op_q    <= slot_op_d;
            slot_data_q  <= slot_data_d;
            slot_count_q <= slot_count_d;
        end
    end
`endif

endmodule

// File: doc/usr_shift_sequencer.md
USR_SHIFT_SEQUENCER -- requirements
Module: usr_shift_sequencer

Interface
REQ-001 Parameter: WIDTH, default 4, data register width (>=2).
REQ-002 Port: clock  input  1  sole clock, rising-edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: cmd_valid  input  1  command present.
REQ-005 Port: cmd_ready  output  1  command can be accepted this cycle.
REQ-006 Port: cmd_op  input  2  00 HOLD, 01 ROTR, 10 ROTL, 11 LOAD.
REQ-007 Port: cmd_data  input  WIDTH  load value, used by LOAD only.
REQ-008 Port: cmd_count  input  4  rotate steps 0..15, used by ROTR/ROTL only.
REQ-009 Port: flush  input  1  synchronous abort of the current command.
REQ-010 Port: data_out  output  WIDTH  register contents.
REQ-011 Port: busy  output  1  high whenever state is not IDLE.
REQ-012 Port: done  output  1  one-cycle completion pulse.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE; all outputs SHALL be registered or decoded from state only.
REQ-014 A command SHALL be accepted at a rising edge where cmd_valid and cmd_ready are both high.
REQ-015 Accepting LOAD SHALL write cmd_data to data_out at that edge, then go to DONE.
REQ-016 Accepting HOLD, or ROTR/ROTL with cmd_count=0, SHALL leave data_out unchanged, then go to DONE.
REQ-017 Accepting ROTR/ROTL with cmd_count=k>0 SHALL latch op and k, then go to RUN.
REQ-018 In RUN, each edge SHALL rotate data_out by one bit (ROTR: {d[0],d[W-1:1]}; ROTL: {d[W-2:0],d[W-1]}) and decrement the counter; the edge performing the k-th rotate SHALL go to DONE.
REQ-019 Latency: accept at edge N; rotates at edges N+1..N+k; done high for the cycle after edge N+k (after edge N for LOAD/HOLD/count 0).
REQ-020 DONE SHALL last exactly one cycle, then go to IDLE (or per REQ-029).
REQ-021 Without USR_SEQ_QUEUE_EN, cmd_ready SHALL equal (state==IDLE) and flush low.
REQ-022 flush high at an edge in RUN or DONE SHALL go to IDLE with no done pulse; data_out keeps its value at that edge; the counter is cleared.
REQ-023 flush in IDLE SHALL have no effect and SHALL block acceptance that cycle.
REQ-024 cmd_op and cmd_data changes while not accepted SHALL not affect data_out.

Reset
REQ-025 Reset high SHALL immediately force: state IDLE, data_out 0, counter 0, done 0, busy 0, queue slot empty.
REQ-026 cmd_ready SHALL be 0 while reset is high and 1 in the first cycle after release.
REQ-027 Reset asserted mid-RUN SHALL abandon the command with no done pulse.

Configuration
REQ-028 Macro USR_SEQ_QUEUE_EN SHALL add a one-entry command slot; absent, the block SHALL have no slot and cmd_ready follows REQ-021.
REQ-029 With USR_SEQ_QUEUE_EN: cmd_ready = (IDLE or slot empty) and flush low; a command accepted in RUN/DONE is stored in the slot; leaving DONE with a full slot SHALL execute the stored command at that edge per REQ-015..017, with no IDLE cycle.
REQ-030 With USR_SEQ_QUEUE_EN, flush SHALL also empty the slot.

Verification
REQ-031 Reset, LOAD 4'b1011 at edge N -> data_out=1011 after N, done=1 for cycle N..N+1, busy 1 for one cycle.
REQ-032 From 1011, ROTR count 1 -> data_out=1101 after edge N+1, done cycle after.
REQ-033 From 1011, ROTL count 3 -> 0111, 1110, 1101 on edges N+1..N+3; done after N+3; cmd_ready low throughout.
REQ-034 From 1101, ROTR count 0 -> data_out stays 1101, done after edge N.
REQ-035 ROTL count 15 from 0001, reset asserted after 5 rotates -> data_out 0 asynchronously, no done, cmd_ready 1 after release.
REQ-036 USR_SEQ_QUEUE_EN: ROTR count 2 then LOAD 0110 presented during RUN -> LOAD accepted while busy, data_out=0110 at the edge leaving first DONE, two done pulses one cycle apart.
